// File: rtl/psum_collector.sv
// ============================================================================
// Module   : psum_collector
// Purpose  : Accumulates PE partial-sum rows over several input-channel passes
//            and drains the finished row downstream over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module psum_collector #(
    parameter int DEPTH = 16,
    parameter int W     = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [3:0]   cfg_len,
    input  logic [3:0]   cfg_passes,
    input  logic [W-1:0] opsum_noc,
    input  logic         opsum_enable,
    output logic         opsum_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic         done
);

    localparam int c_IDX_W = $clog2(DEPTH);
    localparam int c_LEN_W = c_IDX_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [3:0]           r_pass;
    logic [c_LEN_W-1:0]   r_len;
    logic [3:0]           r_passes;
    logic [W-1:0]         r_buf [DEPTH];
    logic                 r_done;

    logic                 w_accept;
    logic                 w_drain_hs;
    logic                 w_idx_last;
    logic                 w_pass_last;

    assign w_idx_last  = ({1'b0, r_idx} == (r_len - 1'b1));
    assign w_pass_last = (r_pass == (r_passes - 4'd1));
    assign w_accept    = (r_state == ACCUM) && opsum_enable;
    assign w_drain_hs  = (r_state == DRAIN) && out_ready;
    assign done        = r_done;

    always_comb begin
        w_state_nxt = r_state;
        opsum_ready = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = ACCUM;
            end
            ACCUM: begin
                busy        = 1'b1;
                opsum_ready = 1'b1;
                if (w_accept && w_idx_last && w_pass_last) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = w_idx_last;
                out_data  = r_buf[r_idx];
                if (w_drain_hs && w_idx_last) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_pass   <= '0;
            r_len    <= c_LEN_W'(DEPTH);
            r_passes <= 4'd1;
            r_done   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_drain_hs && w_idx_last;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len    <= (cfg_len == 4'd0) ? c_LEN_W'(DEPTH) : c_LEN_W'(cfg_len);
                        r_passes <= (cfg_passes == 4'd0) ? 4'd1 : cfg_passes;
                        r_idx    <= '0;
                        r_pass   <= '0;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        // First pass overwrites so stale row data never needs clearing.
                        r_buf[r_idx] <= (r_pass == 4'd0) ? opsum_noc : r_buf[r_idx] + opsum_noc;
                        if (w_idx_last) begin
                            r_idx <= '0;
                            if (!w_pass_last) r_pass <= r_pass + 4'd1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_drain_hs) r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
                end
                default: r_idx <= '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_psum_collector.sv
// ============================================================================
// Module   : tb_psum_collector
// Purpose  : Directed self-checking bench for psum_collector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_psum_collector;

    localparam int W = 24;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   cfg_len;
    logic [3:0]   cfg_passes;
    logic [W-1:0] opsum_noc;
    logic         opsum_enable;
    logic         opsum_ready;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    psum_collector #(.DEPTH(16), .W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .cfg_len      (cfg_len),
        .cfg_passes   (cfg_passes),
        .opsum_noc    (opsum_noc),
        .opsum_enable (opsum_enable),
        .opsum_ready  (opsum_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_start(input logic [3:0] len, input logic [3:0] passes);
        start = 1'b1; cfg_len = len; cfg_passes = passes;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_ready", opsum_ready, 1);
    endtask

    task automatic send(input logic [W-1:0] v, input bit bubble);
        int k = 0;
        if (bubble) begin
            opsum_enable = 1'b0;
            @(negedge clk);
        end
        opsum_noc = v; opsum_enable = 1'b1;
        while (!opsum_ready && k < 100) begin @(negedge clk); k++; end
        check("accept_ready", opsum_ready, 1);
        @(negedge clk);
        opsum_enable = 1'b0;
    endtask

    task automatic recv(input logic [W-1:0] exp, input bit exp_last, input int stall);
        int k = 0;
        out_ready = 1'b0;
        while (!out_valid && k < 100) begin @(negedge clk); k++; end
        check("drain_valid", out_valid, 1);
        check("drain_data", out_data, exp);
        check("drain_last", out_last, exp_last);
        check("drain_opsum_ready", opsum_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, exp);
            check("stall_last", out_last, exp_last);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_done();
        check("done_pulse", done, 1);
        check("done_idle", busy, 0);
        @(negedge clk);
        check("done_low", done, 0);
    endtask

    task automatic three_channel(input bit bubble, input int stall_at);
        logic [W-1:0] rows [9] = '{1, 2, 3, 10, 20, 30, 100, 200, 300};
        logic [W-1:0] sums [3] = '{111, 222, 333};
        do_start(4'd3, 4'd3);
        for (int i = 0; i < 9; i++) send(rows[i], bubble);
        for (int i = 0; i < 3; i++) recv(sums[i], i == 2, (i == stall_at) ? 4 : 0);
        check_done();
    endtask

    initial begin
        int saved_done;
        rst = 1'b0; start = 1'b0; cfg_len = 4'd0; cfg_passes = 4'd0;
        opsum_noc = '0; opsum_enable = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("reset_outputs", {opsum_ready, out_valid, out_last, busy, done}, 0);
        check("reset_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Single pass
        do_start(4'd3, 4'd1);
        send(5, 0); send(7, 0); send(9, 0);
        recv(5, 0, 0); recv(7, 0, 0); recv(9, 1, 0);
        check_done();

        // Three-channel accumulate, then with bubbles and back-pressure
        three_channel(0, -1);
        three_channel(1, 1);

        // Wrap and defaults: len 16, two passes
        do_start(4'd0, 4'd2);
        for (int i = 0; i < 32; i++) send(24'hFFFFFF, 0);
        for (int i = 0; i < 16; i++) recv(24'hFFFFFE, i == 15, 0);
        check_done();

        // Reset mid-job during pass 1
        saved_done = done_cnt;
        do_start(4'd3, 4'd2);
        send(11, 0); send(12, 0); send(13, 0); send(14, 0);
        rst = 1'b0;
        #1;
        check("rst_outputs", {opsum_ready, out_valid, out_last, busy, done}, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        check("rst_hold", {opsum_ready, out_valid, out_last, busy, done}, 0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_release_idle", busy, 0);
        check("rst_no_done", done_cnt, saved_done);
        do_start(4'd2, 4'd1);
        send(4, 0); send(6, 0);
        recv(4, 0, 0); recv(6, 1, 0);
        check_done();

        // Start ignored in ACCUM and DRAIN
        do_start(4'd2, 4'd2);
        send(1, 0); send(2, 0);
        start = 1'b1; cfg_len = 4'd5; cfg_passes = 4'd1;
        @(negedge clk);
        start = 1'b0;
        check("ign_accum_busy", busy, 1);
        send(3, 0); send(4, 0);
        check("ign_drain_valid", out_valid, 1);
        start = 1'b1; cfg_len = 4'd7; cfg_passes = 4'd3;
        @(negedge clk);
        start = 1'b0;
        recv(4, 0, 0); recv(6, 1, 0);
        check_done();
        check("ign_final_idle", {busy, out_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/psum_collector.md
# psum_collector

Downstream companion to the PE row engine. It consumes the PE's 24-bit output partial-sum stream over the opsum enable/ready handshake and accumulates successive row passes (one per input channel) into a local buffer. When the pass count completes, it drains the finished row to the next stage (GLB or next PE column) over a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 16: buffer entries; maximum psums per row.
- W, 24: psum width; matches the PE's opsum_noc.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a job; honoured only in IDLE.
- cfg_len  input  4  psums per row; 0 means 16.
- cfg_passes  input  4  row passes to accumulate; 0 means 1.
- opsum_noc  input  W  psum from the PE.
- opsum_enable  input  1  PE has a valid psum.
- opsum_ready  output  1  collector accepts a psum; goes to the PE.
- out_data  output  W  accumulated psum.
- out_valid  output  1  out_data is valid.
- out_last  output  1  marks the final element of the row; qualified by out_valid.
- out_ready  input  1  downstream accepts out_data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse after the final drain handshake.

## Operation
- The FSM has three states: IDLE, ACCUM and DRAIN.
- Latched on start: len = (cfg_len == 0) ? 16 : cfg_len, and passes = (cfg_passes == 0) ? 1 : cfg_passes.
  - Once latched, len and passes are stable for the whole job.
  - cfg_* changes after start have no effect.
- Counters: idx counts 0..len-1 and pass counts 0..passes-1.
- IDLE:
  - Outputs are opsum_ready = 0, out_valid = 0, busy = 0.
  - start goes to ACCUM with idx = 0 and pass = 0.
- ACCUM:
  - opsum_ready = 1.
  - An accept is opsum_enable && opsum_ready.
  - On accept, buf[idx] <= (pass == 0) ? opsum_noc : buf[idx] + opsum_noc.
  - The sum is W bits and wraps modulo 2^W, with no saturation.
  - The first pass overwrites, so no clear cycle is needed.
  - On accept with idx == len-1: idx <= 0 and pass <= pass+1.
  - If that accept also has pass == passes-1, go to DRAIN instead of incrementing pass; idx is still set to 0.
  - While opsum_enable is low, nothing changes.
- DRAIN:
  - Outputs are out_valid = 1, out_data = buf[idx] (combinational read of the register array), out_last = (idx == len-1), opsum_ready = 0.
  - On out_valid && out_ready, idx advances.
  - On the handshake with out_last, go to IDLE and pulse done.
  - out_data, out_valid and out_last hold stable while out_ready is low.
- start asserted in ACCUM or DRAIN is ignored.
- Buffer entries at index >= len are never read or written.

## Timing
- Reset (rst low, asynchronous) forces:
  - FSM = IDLE, idx = 0, pass = 0, len = 16, passes = 1.
  - All buf entries = 0.
  - Outputs all 0: opsum_ready, out_valid, out_last, out_data, busy, done.
- Reset asserted mid-job aborts the job immediately. No done pulse is produced, and the first cycle after release is IDLE.
- start sampled at edge t puts the block in ACCUM, with opsum_ready = 1, from cycle t+1.
- Throughput in both ACCUM and DRAIN is one element per cycle when the handshake is continuously asserted.
- The final psum accepted at edge t gives DRAIN, with out_valid = 1 and out_data = buf[0], in cycle t+1. The buf write and the state change take effect on the same edge.
- The final drain handshake at edge t gives IDLE and done = 1 in cycle t+1; done is 0 in cycle t+2.
- Minimum job length is len × passes + len + 1 cycles from start to done when there is no back-pressure.
- start in the same cycle as done is legal, because the state is already IDLE.

## Test plan
- **Single pass:** cfg_len = 3, cfg_passes = 1; feed 5, 7, 9 back-to-back.
  - Response: out stream 5, 7, 9, with out_last on 9.
  - done pulses one cycle after the handshake on 9.
- **Three-channel accumulate:** cfg_len = 3, cfg_passes = 3; feed rows {1,2,3}, {10,20,30}, {100,200,300}.
  - Response: drain 111, 222, 333.
  - opsum_ready is 0 throughout the drain.
- **Back-pressure and bubbles:**
  - Stimulus: the same job as the three-channel case, with opsum_enable toggling every other cycle and out_ready low for 4 cycles mid-drain.
  - Response: identical output values; out_data and out_last stay stable while stalled; no element is lost or duplicated.
- **Wrap and defaults:** cfg_len = 0, cfg_passes = 2; every psum is 24'hFFFFFF in both passes.
  - Response: 16 outputs, each 24'hFFFFFE.
  - out_last is set only on the 16th output.
- **Reset mid-job:**
  - Stimulus: assert rst low during ACCUM at pass 1, then release; then start a new single-pass job with cfg_len = 2 and psums 4, 6.
  - Response: all outputs read 0 while rst is low, and there is no done pulse for the aborted job.
  - The new job outputs 4, 6, so no stale data leaks through.
- **Ignored start:**
  - Stimulus: pulse start while in ACCUM and again while in DRAIN, driving different cfg_len/cfg_passes values at the same time.
  - Response: the job runs to completion with the original len and passes.
